// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types and helpers for the gfx pixel write-combiner.
//   packer_state_e : FSM states of the packer (IDLE, ACCUM, RD, WR)
//   LB             : log2 of the default 256-bit memory word width
//   MSK_MAX_W      : widest mask byte_clean() can inspect
//   bpp_eff()      : pixel depth with 0 (and anything above 32) read as 32
//   bpp_mask()     : 32-bit mask with the low bpp bits set
//   byte_clean()   : 1 when every byte of a mask is either 8'h00 or 8'hFF
package gfx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RD,
    WR
  } packer_state_e;

  localparam int LB = $clog2(256);

  // byte_clean() takes a fixed-width argument; narrower masks are
  // zero-extended by the caller, and all-zero bytes count as clean.
  localparam int MSK_MAX_W = 1024;

  function automatic logic [5:0] bpp_eff(input logic [5:0] bpp);
    return ((bpp == 6'd0) || (bpp > 6'd32)) ? 6'd32 : bpp;
  endfunction

  // A 33-bit intermediate lets a depth of 32 produce all ones without
  // overflowing the shift.
  function automatic logic [31:0] bpp_mask(input logic [5:0] bpp);
    logic [32:0] m;
    m = (33'd1 << bpp_eff(bpp)) - 33'd1;
    return m[31:0];
  endfunction

  function automatic logic byte_clean(input logic [MSK_MAX_W-1:0] msk);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < MSK_MAX_W / 8; b++) begin
      if ((msk[8*b +: 8] != 8'h00) && (msk[8*b +: 8] != 8'hFF)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/gfx_pix_merge.sv
// gfx_pix_merge: combinational merge of one pixel into a line buffer.
//   dat, msk      : current buffer data and per-bit write mask
//   color, bpp    : pixel colour and depth (bits at or above bpp ignored)
//   mb            : bit offset of the pixel LSB within the line
//   merged_dat    : buffer data with the pixel written in
//   merged_msk    : buffer mask with the pixel's bits set
//   straddle      : pixel would run past the end of the line
module gfx_pix_merge
  import gfx_pkg::*;
#(
  parameter int MEM_W = 256
) (
  input  logic [MEM_W-1:0]         dat,
  input  logic [MEM_W-1:0]         msk,
  input  logic [31:0]              color,
  input  logic [5:0]               bpp,
  input  logic [$clog2(MEM_W)-1:0] mb,
  output logic [MEM_W-1:0]         merged_dat,
  output logic [MEM_W-1:0]         merged_msk,
  output logic                     straddle
);

  localparam int MB_W   = $clog2(MEM_W);
  localparam int SPAN_W = MB_W + 2;

  logic [31:0]       pm;
  logic [MEM_W-1:0]  pm_wide;
  logic [MEM_W-1:0]  col_wide;
  logic [SPAN_W-1:0] span;

  // Widen the pixel mask and colour to a full line, shift them into place
  // and splice them over the existing buffer. The span is computed two bits
  // wider than the offset so offset + 32 cannot wrap.
  always_comb begin
    pm         = bpp_mask(bpp);
    pm_wide    = {{(MEM_W-32){1'b0}}, pm} << mb;
    col_wide   = {{(MEM_W-32){1'b0}}, (color & pm)} << mb;
    span       = SPAN_W'(mb) + SPAN_W'(bpp_eff(bpp));
    straddle   = (span > SPAN_W'(MEM_W));
    merged_dat = (dat & ~pm_wide) | col_wide;
    merged_msk = msk | pm_wide;
  end

endmodule

// File: rtl/gfx_pixel_packer.sv
// gfx_pixel_packer: write-combiner merging a pixel stream into one
// memory line and writing it out on line change, flush or idle timeout.
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   pix_valid_i / pix_ready_o    : pixel handshake
//   pix_bitaddr_i, pix_bpp_i,
//   pix_color_i                  : pixel bit address, depth, colour
//   flush_i / flush_done_o       : flush request and completion pulse
//   err_o                        : pulse when a straddling pixel is dropped
//   mem_req_o, mem_we_o,
//   mem_adr_o, mem_sel_o,
//   mem_dat_o                    : registered memory request
//   mem_dat_i, mem_ack_i         : memory read data and completion
module gfx_pixel_packer
  import gfx_pkg::*;
#(
  parameter int MEM_W   = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pix_valid_i,
  output logic                               pix_ready_o,
  input  logic [ADDR_W-1:0]                  pix_bitaddr_i,
  input  logic [5:0]                         pix_bpp_i,
  input  logic [31:0]                        pix_color_i,
  input  logic                               flush_i,
  output logic                               flush_done_o,
  output logic                               err_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [ADDR_W-$clog2(MEM_W)-1:0]    mem_adr_o,
  output logic [MEM_W/8-1:0]                 mem_sel_o,
  output logic [MEM_W-1:0]                   mem_dat_o,
  input  logic [MEM_W-1:0]                   mem_dat_i,
  input  logic                               mem_ack_i
);

  localparam int LINE_LB = $clog2(MEM_W);
  localparam int LINE_W  = ADDR_W - LINE_LB;
  localparam int SEL_W   = MEM_W / 8;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  packer_state_e          state, state_n;
  logic [LINE_W-1:0]      buf_line, buf_line_n, pix_line;
  logic [LINE_LB-1:0]     pix_mb;
  logic [MEM_W-1:0]       buf_dat, buf_dat_n;
  logic [MEM_W-1:0]       buf_msk, buf_msk_n;
  logic [MEM_W-1:0]       mrg_dat, mrg_msk;
  logic [MSK_MAX_W-1:0]   msk_ext;
  logic [CNT_W-1:0]       idle_cnt, idle_cnt_n;
  logic                   flush_pend, flush_pend_n;
  logic                   straddle, same_line, timeout, clean, ack;
  logic                   done_d, err_d, req_d, we_d;
  logic [SEL_W-1:0]       sel_d;
  logic [MEM_W-1:0]       dat_d;

  assign pix_line  = pix_bitaddr_i[ADDR_W-1:LINE_LB];
  assign pix_mb    = pix_bitaddr_i[LINE_LB-1:0];
  assign same_line = (pix_line == buf_line);

  // An ack only counts against a request that is actually outstanding.
  assign ack = mem_ack_i & mem_req_o;

  // The idle counter saturates at TIMEOUT, so reaching it is the trigger.
  assign timeout = (TIMEOUT != 0) && (state == ACCUM) &&
                   (idle_cnt == CNT_W'(TIMEOUT));

  gfx_pix_merge #(
    .MEM_W (MEM_W)
  ) u_merge (
    .dat        (buf_dat),
    .msk        (buf_msk),
    .color      (pix_color_i),
    .bpp        (pix_bpp_i),
    .mb         (pix_mb),
    .merged_dat (mrg_dat),
    .merged_msk (mrg_msk),
    .straddle   (straddle)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, buffer update and pixel handshake. A flush request always
  // wins over a pixel offered in the same cycle; a pixel for another line
  // is held off until the current line has been written back.
  always_comb begin
    state_n      = state;
    buf_line_n   = buf_line;
    buf_dat_n    = buf_dat;
    buf_msk_n    = buf_msk;
    idle_cnt_n   = idle_cnt;
    flush_pend_n = flush_pend;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pix_ready_o  = 1'b0;
    msk_ext      = '0;
    msk_ext[MEM_W-1:0] = buf_msk;
    clean        = byte_clean(msk_ext);

    case (state)
      IDLE: begin
        pix_ready_o = !flush_i;
        if (flush_i) begin
          done_d = 1'b1;
        end else if (pix_valid_i) begin
          err_d = straddle;
          if (!straddle) begin
            buf_line_n = pix_line;
            buf_dat_n  = mrg_dat;
            buf_msk_n  = mrg_msk;
            idle_cnt_n = '0;
            state_n    = ACCUM;
          end
        end
      end

      ACCUM: begin
        pix_ready_o = same_line && !flush_i && !timeout;
        if (flush_i || timeout || (pix_valid_i && !same_line)) begin
          flush_pend_n = flush_i;
          state_n      = clean ? WR : RD;
        end else if (pix_valid_i) begin
          err_d      = straddle;
          idle_cnt_n = '0;
          if (!straddle) begin
            buf_dat_n = mrg_dat;
            buf_msk_n = mrg_msk;
          end
        end else if (idle_cnt != CNT_W'(TIMEOUT)) begin
          idle_cnt_n = idle_cnt + CNT_W'(1);
        end
      end

      RD: begin
        if (flush_i) begin
          flush_pend_n = 1'b1;
        end
        if (ack) begin
          buf_dat_n = (mem_dat_i & ~buf_msk) | (buf_dat & buf_msk);
          buf_msk_n = '1;
          state_n   = WR;
        end
      end

      WR: begin
        if (flush_i) begin
          flush_pend_n = 1'b1;
        end
        if (ack) begin
          buf_msk_n    = '0;
          done_d       = flush_pend || flush_i;
          flush_pend_n = 1'b0;
          state_n      = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Buffer, idle counter, pending-flush flag and the two status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_line     <= '0;
      buf_dat      <= '0;
      buf_msk      <= '0;
      idle_cnt     <= '0;
      flush_pend   <= 1'b0;
      flush_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      buf_line     <= buf_line_n;
      buf_dat      <= buf_dat_n;
      buf_msk      <= buf_msk_n;
      idle_cnt     <= idle_cnt_n;
      flush_pend   <= flush_pend_n;
      flush_done_o <= done_d;
      err_o        <= err_d;
    end
  end

  // Memory request contents for the coming cycle. Every ack forces one
  // cycle with the request low, so a read is followed by a fresh write
  // request rather than a continuation of the read.
  always_comb begin
    req_d = ((state_n == RD) || (state_n == WR)) && !ack;
    we_d  = req_d && (state_n == WR);
    sel_d = '0;
    dat_d = '0;
    if (req_d && (state_n == WR)) begin
      dat_d = buf_dat_n;
      for (int b = 0; b < SEL_W; b++) begin
        sel_d[b] = buf_msk_n[8*b];
      end
    end else if (req_d) begin
      sel_d = '1;
    end
  end

  // Registered memory port, frozen while a request waits for its ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_adr_o <= '0;
      mem_sel_o <= '0;
      mem_dat_o <= '0;
    end else if (!(mem_req_o && !mem_ack_i)) begin
      mem_req_o <= req_d;
      mem_we_o  <= we_d;
      mem_adr_o <= req_d ? buf_line_n : '0;
      mem_sel_o <= sel_d;
      mem_dat_o <= dat_d;
    end
  end

endmodule
